// File: rtl/lsu_pkg.sv
// Shared types and constants for the data-memory load/store unit.
// Memory request/response structs are word-oriented with per-byte enables.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } lsu_state_t;

    localparam logic [2:0] LSU_B  = 3'b000;
    localparam logic [2:0] LSU_H  = 3'b001;
    localparam logic [2:0] LSU_W  = 3'b010;
    localparam logic [2:0] LSU_BU = 3'b100;
    localparam logic [2:0] LSU_HU = 3'b101;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  do_read;
        logic [3:0]  do_write;
        logic        valid;
    } memory_io_req;

    typedef struct packed {
        logic [31:0] data;
        logic        valid;
    } memory_io_rsp;

    // Stores only come in B/H/W; the unsigned codes are load-only.
    function automatic logic funct3_illegal(input logic [2:0] funct3, input logic is_store);
        case (funct3)
            LSU_B, LSU_H, LSU_W: return 1'b0;
            LSU_BU, LSU_HU:      return is_store;
            default:             return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: byte enables, store-data replication,
// misalignment detection and load extraction/extension.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] wdata,
    input  logic [31:0] mem_word,
    output logic [3:0]  byte_en,
    output logic [31:0] store_data,
    output logic        misaligned,
    output logic [31:0] load_data
);

    logic [31:0] shifted;

    always_comb begin
        shifted    = mem_word >> {offset, 3'b000};
        byte_en    = '0;
        store_data = '0;
        misaligned = 1'b0;
        load_data  = '0;
        case (funct3)
            LSU_B, LSU_BU: begin
                byte_en    = 4'b0001 << offset;
                store_data = {4{wdata[7:0]}};
                load_data  = {{24{shifted[7] & ~funct3[2]}}, shifted[7:0]};
            end
            LSU_H, LSU_HU: begin
                byte_en    = 4'b0011 << offset;
                store_data = {2{wdata[15:0]}};
                misaligned = offset[0];
                load_data  = {{16{shifted[15] & ~funct3[2]}}, shifted[15:0]};
            end
            LSU_W: begin
                byte_en    = 4'b1111;
                store_data = wdata;
                misaligned = |offset;
                load_data  = mem_word;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/data_mem_lsu.sv
// Load/store unit: accepts one core access at a time, issues a single word
// request to data memory, waits (with timeout) and returns the extended result.
module data_mem_lsu
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         lsu_valid,
    input  logic         lsu_is_store,
    input  logic [2:0]   lsu_funct3,
    input  logic [31:0]  lsu_addr,
    input  logic [31:0]  lsu_wdata,
    output logic         lsu_ready,
    output logic         lsu_done,
    output logic [31:0]  lsu_rdata,
    output logic         lsu_error,
    output memory_io_req data_mem_req,
    input  memory_io_rsp data_mem_rsp,
    output logic         data_mem_req_ack
);

    lsu_state_t  state, next_state;
    logic        is_store_q, err_q;
    logic [2:0]  funct3_q;
    logic [31:0] addr_q, wdata_q, word_q, cnt;

    logic [2:0]  sel_funct3;
    logic [1:0]  sel_offset;
    logic [3:0]  byte_en;
    logic [31:0] store_data, load_data;
    logic        misaligned, access_err, timeout;

    // In IDLE the aligner looks at the live request to decide accept vs error;
    // afterwards it works from the captured copy.
    assign sel_funct3 = (state == IDLE) ? lsu_funct3     : funct3_q;
    assign sel_offset = (state == IDLE) ? lsu_addr[1:0]  : addr_q[1:0];
    assign access_err = misaligned | funct3_illegal(lsu_funct3, lsu_is_store);
    assign timeout    = (cnt == 32'(TIMEOUT_CYCLES - 1));

    lsu_align u_align (
        .funct3     (sel_funct3),
        .offset     (sel_offset),
        .wdata      (wdata_q),
        .mem_word   (word_q),
        .byte_en    (byte_en),
        .store_data (store_data),
        .misaligned (misaligned),
        .load_data  (load_data)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            is_store_q <= 1'b0;
            err_q      <= 1'b0;
            funct3_q   <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            word_q     <= '0;
            cnt        <= '0;
        end else begin
            state <= next_state;
            case (state)
                IDLE: if (lsu_valid) begin
                    is_store_q <= lsu_is_store;
                    funct3_q   <= lsu_funct3;
                    addr_q     <= lsu_addr;
                    wdata_q    <= lsu_wdata;
                    err_q      <= access_err;
                    word_q     <= '0;
                end
                ISSUE: cnt <= '0;
                WAIT: begin
                    if (data_mem_rsp.valid) word_q <= data_mem_rsp.data;
                    else if (timeout)       err_q  <= 1'b1;
                    else                    cnt    <= cnt + 32'd1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (lsu_valid) next_state = access_err ? RESP : ISSUE;
            ISSUE:   next_state = WAIT;
            WAIT:    if (data_mem_rsp.valid || timeout) next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        lsu_ready        = (state == IDLE);
        lsu_done         = (state == RESP);
        lsu_error        = (state == RESP) && err_q;
        lsu_rdata        = ((state == RESP) && !err_q && !is_store_q) ? load_data : '0;
        data_mem_req_ack = (state == WAIT) && data_mem_rsp.valid;
        data_mem_req     = '0;
        if (state == ISSUE || state == WAIT) begin
            data_mem_req.addr     = {addr_q[31:2], 2'b00};
            data_mem_req.data     = is_store_q ? store_data : '0;
            data_mem_req.do_read  = is_store_q ? 4'b0000 : byte_en;
            data_mem_req.do_write = is_store_q ? byte_en : 4'b0000;
            data_mem_req.valid    = (state == ISSUE);
        end
    end

endmodule

// File: tb/tb_data_mem_lsu.sv
// Directed plus randomized bench for data_mem_lsu against an arithmetic
// reference model of RV32I load/store lane behaviour.
module tb_data_mem_lsu;
    import lsu_pkg::*;

    logic         clk = 1'b0;
    logic         reset;
    logic         lsu_valid, lsu_is_store;
    logic [2:0]   lsu_funct3;
    logic [31:0]  lsu_addr, lsu_wdata;
    logic         lsu_ready, lsu_done, lsu_error, data_mem_req_ack;
    logic [31:0]  lsu_rdata;
    memory_io_req req;
    memory_io_rsp rsp;

    int total = 0;
    int bad   = 0;

    data_mem_lsu #(.TIMEOUT_CYCLES(4)) dut (
        .clk              (clk),
        .reset            (reset),
        .lsu_valid        (lsu_valid),
        .lsu_is_store     (lsu_is_store),
        .lsu_funct3       (lsu_funct3),
        .lsu_addr         (lsu_addr),
        .lsu_wdata        (lsu_wdata),
        .lsu_ready        (lsu_ready),
        .lsu_done         (lsu_done),
        .lsu_rdata        (lsu_rdata),
        .lsu_error        (lsu_error),
        .data_mem_req     (req),
        .data_mem_rsp     (rsp),
        .data_mem_req_ack (data_mem_req_ack)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Access width in bytes; 0 marks an undefined code.
    function automatic int width_of(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            3'b010:         return 4;
            default:        return 0;
        endcase
    endfunction

    function automatic bit legal(input bit st, input logic [2:0] f3, input logic [31:0] addr);
        int w = width_of(f3);
        if (w == 0) return 0;
        if (st && f3 > 3'b010) return 0;
        return (addr % w) == 0;
    endfunction

    function automatic logic [3:0] exp_be(input logic [2:0] f3, input logic [31:0] addr);
        longint m;
        m = ((longint'(1) << width_of(f3)) - 1) << (addr % 4);
        return m[3:0];
    endfunction

    function automatic logic [31:0] exp_sdata(input logic [2:0] f3, input logic [31:0] wd);
        int     w = width_of(f3);
        longint piece, r;
        piece = longint'(wd) & ((longint'(1) << (8 * w)) - 1);
        r = 0;
        for (int i = 0; i < 4; i += w) r = r | (piece << (8 * i));
        return r[31:0];
    endfunction

    function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] word);
        int     w = width_of(f3);
        longint v;
        v = (longint'(word) >> (8 * (addr % 4))) & ((longint'(1) << (8 * w)) - 1);
        if ((f3 == 3'b000 || f3 == 3'b001) && v >= (longint'(1) << (8 * w - 1)))
            v = v - (longint'(1) << (8 * w));
        return v[31:0];
    endfunction

    // dly = WAIT cycle (1-based) in which memory answers; 0 = never answers.
    task automatic access(input bit st, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [31:0] word, input int dly);
        bit          ok = legal(st, f3, addr);
        logic [3:0]  be = ok ? exp_be(f3, addr) : 4'b0000;
        logic [31:0] sd = (ok && st) ? exp_sdata(f3, wd) : 32'h0;
        logic [31:0] wa = {addr[31:2], 2'b00};
        int          n  = (dly == 0) ? 4 : dly;
        check1("ready_before", lsu_ready, 1'b1);
        lsu_valid = 1'b1; lsu_is_store = st; lsu_funct3 = f3; lsu_addr = addr; lsu_wdata = wd;
        tick();
        lsu_valid = 1'b0; lsu_is_store = ~st; lsu_funct3 = 3'($urandom);
        lsu_addr = $urandom; lsu_wdata = $urandom;
        if (!ok) begin
            check1("err_done", lsu_done, 1'b1);
            check1("err_flag", lsu_error, 1'b1);
            check32("err_rdata", lsu_rdata, 32'h0);
            check1("err_no_req", req.valid, 1'b0);
            tick();
            check1("err_ready_after", lsu_ready, 1'b1);
            check1("err_done_after", lsu_done, 1'b0);
            return;
        end
        check1("issue_valid", req.valid, 1'b1);
        check32("issue_addr", req.addr, wa);
        check32("issue_rd", {28'h0, req.do_read}, {28'h0, st ? 4'b0000 : be});
        check32("issue_wr", {28'h0, req.do_write}, {28'h0, st ? be : 4'b0000});
        check32("issue_data", req.data, sd);
        check1("issue_ready", lsu_ready, 1'b0);
        check1("issue_done", lsu_done, 1'b0);
        check1("issue_error", lsu_error, 1'b0);
        rsp.valid = 1'b1; rsp.data = $urandom;
        #1;
        check1("issue_rsp_ignored", data_mem_req_ack, 1'b0);
        tick();
        rsp.valid = 1'b0;
        for (int k = 1; k <= n; k++) begin
            check1("wait_valid", req.valid, 1'b0);
            check32("wait_addr", req.addr, wa);
            check32("wait_data", req.data, sd);
            check1("wait_done", lsu_done, 1'b0);
            check32("wait_rdata", lsu_rdata, 32'h0);
            if (k == dly) begin
                rsp.valid = 1'b1; rsp.data = word;
                #1;
                check1("wait_ack", data_mem_req_ack, 1'b1);
            end else begin
                #1;
                check1("wait_no_ack", data_mem_req_ack, 1'b0);
            end
            tick();
            rsp.valid = 1'b0;
        end
        check1("resp_done", lsu_done, 1'b1);
        check1("resp_error", lsu_error, dly == 0);
        check32("resp_rdata", lsu_rdata, (dly == 0 || st) ? 32'h0 : exp_load(f3, addr, word));
        check1("resp_ready", lsu_ready, 1'b0);
        check1("resp_ack", data_mem_req_ack, 1'b0);
        tick();
        check1("idle_ready", lsu_ready, 1'b1);
        check1("idle_done", lsu_done, 1'b0);
    endtask

    initial begin
        reset = 1'b0; lsu_valid = 1'b0; lsu_is_store = 1'b0; lsu_funct3 = '0;
        lsu_addr = '0; lsu_wdata = '0; rsp = '0;
        #1;
        check1("rst_ready", lsu_ready, 1'b1);
        check1("rst_done", lsu_done, 1'b0);
        check1("rst_error", lsu_error, 1'b0);
        check32("rst_rdata", lsu_rdata, 32'h0);
        check1("rst_req_valid", req.valid, 1'b0);
        check32("rst_req_addr", req.addr, 32'h0);
        tick(); tick();
        reset = 1'b1;
        tick();

        access(1'b0, LSU_B,  32'h0000_0103, 32'h0,         32'h80FF_1234, 1);
        access(1'b1, LSU_H,  32'h0000_0202, 32'h0000_ABCD, 32'h0,         1);
        access(1'b0, LSU_W,  32'h0000_0201, 32'h0,         32'h0,         1);
        access(1'b0, LSU_HU, 32'h0000_0202, 32'h0,         32'h8001_0000, 2);
        access(1'b0, LSU_W,  32'h0000_0400, 32'h0,         32'hDEAD_BEEF, 0);
        access(1'b0, LSU_H,  32'h0000_0402, 32'h0,         32'h9ABC_1234, 4);
        access(1'b1, LSU_BU, 32'h0000_0400, 32'h55,        32'h0,         1);
        access(1'b0, 3'b011, 32'h0000_0400, 32'h0,         32'h0,         1);

        for (int i = 0; i < 40; i++) begin
            logic [31:0] a = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'($urandom_range(0, 1) * 2);
            access(1'($urandom), 3'($urandom), a, $urandom, $urandom,
                   ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 4));
        end

        // Reset in WAIT abandons the access; a late response is ignored.
        lsu_valid = 1'b1; lsu_is_store = 1'b0; lsu_funct3 = LSU_W; lsu_addr = 32'h0000_0800;
        tick();
        lsu_valid = 1'b0;
        tick();
        reset = 1'b0;
        #1;
        check1("midrst_ready", lsu_ready, 1'b1);
        check1("midrst_done", lsu_done, 1'b0);
        check1("midrst_req", req.valid, 1'b0);
        check32("midrst_req_rd", {28'h0, req.do_read}, 32'h0);
        tick();
        reset = 1'b1;
        rsp.valid = 1'b1; rsp.data = 32'h1234_5678;
        #1;
        check1("late_rsp_ack", data_mem_req_ack, 1'b0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check1("late_rsp_done", lsu_done, 1'b0);
            check1("late_rsp_ready", lsu_ready, 1'b1);
        end
        rsp.valid = 1'b0;
        access(1'b0, LSU_BU, 32'h0000_0801, 32'h0, 32'h1234_8056, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/data_mem_lsu.md
DATA_MEM_LSU -- requirements
Module: data_mem_lsu

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: maximum WAIT-state cycles before an access aborts with error.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 lsu_valid  input  1  core presents a load/store.
REQ-005 lsu_is_store  input  1  1=store, 0=load.
REQ-006 lsu_funct3  input  3  RV32I width/sign code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-007 lsu_addr  input  32  byte address.
REQ-008 lsu_wdata  input  32  store data, right-justified.
REQ-009 lsu_ready  output  1  LSU can accept; core stalls while low.
REQ-010 lsu_done  output  1  one-cycle completion pulse.
REQ-011 lsu_rdata  output  32  extended load result; valid with lsu_done.
REQ-012 lsu_error  output  1  with lsu_done: misaligned, illegal funct3 or timeout.
REQ-013 data_mem_req  output  memory_io_req  word request (addr, data, do_read, do_write, valid).
REQ-014 data_mem_rsp  input  memory_io_rsp  memory response (data, valid).
REQ-015 data_mem_req_ack  output  1  acknowledges the consumed response.

Function
REQ-016 FSM states IDLE, ISSUE, WAIT, RESP; lsu_ready SHALL equal (state==IDLE).
REQ-017 IDLE: lsu_valid high registers all lsu_* inputs; go to ISSUE, or RESP with error if misaligned/illegal.
REQ-018 Misaligned: H/HU with addr[0]=1, W with addr[1:0]!=0; illegal: funct3 011/110/111, or store funct3 other than 000/001/010.
REQ-019 ISSUE: data_mem_req.valid=1 for exactly this cycle; always go to WAIT.
REQ-020 data_mem_req.addr = {addr[31:2],2'b00}; addr, data, do_read, do_write held stable from ISSUE until leaving WAIT.
REQ-021 Byte enables: B 4'b0001<<addr[1:0], H 4'b0011<<addr[1:0], W 4'b1111; drive do_write for stores, do_read for loads, other field 0.
REQ-022 Store data lane-replicated: B {4{wdata[7:0]}}, H {2{wdata[15:0]}}, W wdata.
REQ-023 WAIT: data_mem_rsp.valid high asserts data_mem_req_ack same cycle, captures rsp data, go to RESP.
REQ-024 rsp.valid in IDLE, ISSUE or RESP is ignored and not acknowledged; memory responds no earlier than cycle after ISSUE.
REQ-025 WAIT counter cleared on entry; count reaching TIMEOUT_CYCLES with no rsp.valid goes to RESP with error, no ack.
REQ-026 RESP: lsu_done=1 for one cycle, then IDLE; lsu_ready stays low during RESP.
REQ-027 Load extraction: lane selected by addr[1:0]; B/H sign-extend, BU/HU zero-extend, W unchanged.
REQ-028 lsu_rdata=0 for stores and error completions; lsu_rdata/lsu_error low whenever lsu_done is low.
REQ-029 Minimum latency: accept cycle N, ISSUE N+1, rsp.valid at N+2, lsu_done at N+3; error-on-accept lsu_done at N+1.

Reset
REQ-030 reset low forces IDLE asynchronously; counter, captured data and all outputs 0 (lsu_ready=1 once IDLE).
REQ-031 Reset mid-access abandons it: no lsu_done; any later response for it is ignored per REQ-024.

Structure
REQ-032 Package lsu_pkg holds state enum, funct3 constants (LSU_B, LSU_H, LSU_W, LSU_BU, LSU_HU) and memory_io_req/rsp types.
REQ-033 Combinational sub-module lsu_align produces byte enables, replicated store data, misaligned flag and extended load data; FSM, counter and registers stay in data_mem_lsu.

Verification
REQ-034 LB addr 0x103, mem word 0x80FF_1234, rsp 1 cycle after ISSUE -> do_read 4'b1000, req.addr 0x100, lsu_rdata 0xFFFF_FF80, lsu_done at N+3.
REQ-035 SH addr 0x202, wdata 0x0000_ABCD -> do_write 4'b1100, req.data 0xABCD_ABCD, lsu_done with rdata 0, error 0.
REQ-036 LW addr 0x201 -> no req.valid ever, lsu_done+lsu_error at N+1; LHU addr 0x202 word 0x8001_0000 -> rdata 0x0000_8001.
REQ-037 TIMEOUT_CYCLES=4, no rsp.valid -> lsu_done+lsu_error after 4 WAIT cycles, data_mem_req_ack never high.
REQ-038 reset low during WAIT, then rsp.valid -> state IDLE, no lsu_done, no ack, lsu_ready=1.
